// File: rtl/hard_mem_1rw_mask_banked_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : hard_mem_1rw_mask_banked_wrapper
// Brief    : 1RW masked memory built from depth-tiled fakeram45 banks, with
//            power-on zero init, read-valid pulse and held read data.
//            Option macro HARD_MEM_OUT_REG_EN adds an output register (latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module hard_mem_1rw_mask_banked_wrapper #(
   parameter  int WIDTH      = 64,
   parameter  int DEPTH      = 512,
   parameter  int BANK_DEPTH = 64,
   parameter  int MASK_GRAN  = 8,
   localparam int MASK_W     = WIDTH / MASK_GRAN,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              v_i,
   input  logic              w_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIDTH-1:0]  data_i,
   input  logic [MASK_W-1:0] w_mask_i,
   output logic              ready_o,
   output logic              v_o,
   output logic [WIDTH-1:0]  data_o
);

   localparam int c_NUM_BANKS = DEPTH / BANK_DEPTH;
   localparam int c_BANK_AW   = $clog2(BANK_DEPTH);
   localparam int c_SEL_W     = (c_NUM_BANKS > 1) ? $clog2(c_NUM_BANKS) : 1;
   localparam bit c_SUPPORTED =
      ((BANK_DEPTH == 64)  && (WIDTH == 32 || WIDTH == 64 || WIDTH == 96 || WIDTH == 128)) ||
      ((BANK_DEPTH == 128) && (WIDTH == 32 || WIDTH == 64)) ||
      ((BANK_DEPTH == 256) && (WIDTH == 64));
   localparam logic [c_BANK_AW-1:0] c_INIT_LAST = c_BANK_AW'(BANK_DEPTH - 1);

   typedef enum logic [0:0] {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [c_BANK_AW-1:0]   r_init_cnt;
   logic [c_BANK_AW-1:0]   w_cnt_nxt;
   logic [c_NUM_BANKS-1:0] w_sel_oh;
   logic [c_NUM_BANKS-1:0] w_ce;
   logic                   w_we;
   logic [c_BANK_AW-1:0]   w_baddr;
   logic [WIDTH-1:0]       w_wd;
   logic [WIDTH-1:0]       w_bmask;
   logic [WIDTH-1:0]       w_req_mask;
   logic                   w_rd_acc;
   logic [WIDTH-1:0]       w_bank_rd [c_NUM_BANKS];
   logic [WIDTH-1:0]       w_rd_mux;
   logic                   r_rd_v;
   logic                   w_out_v;
   logic [WIDTH-1:0]       w_out_d;
   logic [WIDTH-1:0]       r_hold;

   if ((WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
      $error("WIDTH must be a multiple of MASK_GRAN");
   end
   if ((DEPTH % BANK_DEPTH) != 0 || (1 << ADDR_W) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and a multiple of BANK_DEPTH");
   end
   if (!c_SUPPORTED) begin : g_unsupported
      $error("no fakeram45 macro for this BANK_DEPTH x WIDTH");
   end

   for (genvar k = 0; k < MASK_W; k++) begin : g_mask
      assign w_req_mask[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{w_mask_i[k]}};
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_init_cnt;
      w_ce        = '0;
      w_we        = 1'b0;
      w_baddr     = addr_i[c_BANK_AW-1:0];
      w_wd        = data_i;
      w_bmask     = w_req_mask;
      w_rd_acc    = 1'b0;
      case (r_state)
         S_INIT: begin
            // Every bank is cleared in parallel, so init takes BANK_DEPTH cycles.
            w_ce      = '1;
            w_we      = 1'b1;
            w_baddr   = r_init_cnt;
            w_wd      = '0;
            w_bmask   = '1;
            w_cnt_nxt = r_init_cnt + c_BANK_AW'(1);
            if (r_init_cnt == c_INIT_LAST) begin
               w_state_nxt = S_READY;
            end
         end
         S_READY: begin
            if (v_i) begin
               w_ce     = w_sel_oh;
               w_we     = w_i;
               w_rd_acc = ~w_i;
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   assign ready_o = (r_state == S_READY);

   if (c_NUM_BANKS > 1) begin : g_multi_bank
      logic [c_SEL_W-1:0] w_bank_sel;
      logic [c_SEL_W-1:0] r_rd_bank;

      assign w_bank_sel = addr_i[ADDR_W-1:c_BANK_AW];
      assign w_sel_oh   = c_NUM_BANKS'(1) << w_bank_sel;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            r_rd_bank <= '0;
         end else if (w_rd_acc) begin
            r_rd_bank <= w_bank_sel;
         end
      end

      assign w_rd_mux = w_bank_rd[r_rd_bank];
   end else begin : g_single_bank
      assign w_sel_oh = '1;
      assign w_rd_mux = w_bank_rd[0];
   end

   // Behavioural stand-in for the fakeram45_<BANK_DEPTH>x<WIDTH> hard macro.
   for (genvar b = 0; b < c_NUM_BANKS; b++) begin : g_bank
      if (c_SUPPORTED) begin : g_fakeram45
         logic [WIDTH-1:0] r_mem [BANK_DEPTH];
         logic [WIDTH-1:0] r_rd_out;

         always_ff @(posedge clk_i) begin
            if (w_ce[b]) begin
               if (w_we) begin
                  r_mem[w_baddr] <= (w_wd & w_bmask) | (r_mem[w_baddr] & ~w_bmask);
               end else begin
                  r_rd_out <= r_mem[w_baddr];
               end
            end
         end

         assign w_bank_rd[b] = r_rd_out;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_rd_v <= 1'b0;
      end else begin
         r_rd_v <= w_rd_acc;
      end
   end

`ifdef HARD_MEM_OUT_REG_EN
   logic             r_pipe_v;
   logic [WIDTH-1:0] r_pipe_d;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_pipe_v <= 1'b0;
         r_pipe_d <= '0;
      end else begin
         r_pipe_v <= r_rd_v;
         if (r_rd_v) begin
            r_pipe_d <= w_rd_mux;
         end
      end
   end

   assign w_out_v = r_pipe_v;
   assign w_out_d = r_pipe_d;
`else
   assign w_out_v = r_rd_v;
   assign w_out_d = w_rd_mux;
`endif

   // The hold register keeps data_o stable while the macro output is not valid.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_hold <= '0;
      end else if (w_out_v) begin
         r_hold <= w_out_d;
      end
   end

   assign v_o    = w_out_v;
   assign data_o = w_out_v ? w_out_d : r_hold;

endmodule
`default_nettype wire

// File: tb/tb_hard_mem_1rw_mask_banked_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_hard_mem_1rw_mask_banked_wrapper
// Brief    : Scoreboard bench for a byte-mask banked instance and a bit-mask
//            single-bank instance of hard_mem_1rw_mask_banked_wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hard_mem_1rw_mask_banked_wrapper;

`ifdef HARD_MEM_OUT_REG_EN
   localparam int c_LAT = 2;
`else
   localparam int c_LAT = 1;
`endif
   localparam int c_INIT = 64;

   typedef struct {
      logic [95:0] d;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        a_v, a_w, a_ready, a_v_o;
   logic [8:0]  a_addr;
   logic [63:0] a_data, a_data_o;
   logic [7:0]  a_mask;
   logic        b_v, b_w, b_ready, b_v_o;
   logic [5:0]  b_addr;
   logic [95:0] b_data, b_data_o, b_mask;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          edges = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic [63:0] ma [int];
   logic [95:0] mb [int];
   logic [63:0] a_last = '0;
   logic [95:0] b_last = '0;

   hard_mem_1rw_mask_banked_wrapper u_dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(a_v), .w_i(a_w), .addr_i(a_addr),
      .data_i(a_data), .w_mask_i(a_mask), .ready_o(a_ready), .v_o(a_v_o), .data_o(a_data_o)
   );

   hard_mem_1rw_mask_banked_wrapper #(
      .WIDTH(96), .DEPTH(64), .BANK_DEPTH(64), .MASK_GRAN(1)
   ) u_dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .v_i(b_v), .w_i(b_w), .addr_i(b_addr),
      .data_i(b_data), .w_mask_i(b_mask), .ready_o(b_ready), .v_o(b_v_o), .data_o(b_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (rst_n) edges++;
      else       edges = 0;
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      logic        ev;
      logic [63:0] ed;
      if (!rst_n) begin
         qa.delete();
         a_last = '0;
         chk("a_rst_ready", 96'(a_ready), 96'(0));
         chk("a_rst_v_o", 96'(a_v_o), 96'(0));
         chk("a_rst_data_o", 96'(a_data_o), 96'(0));
      end else begin
         ev = (qa.size() > 0) && (qa[0].cyc == cyc);
         ed = ev ? qa[0].d[63:0] : a_last;
         chk("a_ready", 96'(a_ready), 96'(edges >= c_INIT));
         chk("a_v_o", 96'(a_v_o), 96'(ev));
         chk("a_data_o", 96'(a_data_o), 96'(ed));
         if (ev) begin
            a_last = ed;
            void'(qa.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      logic        ev;
      logic [95:0] ed;
      if (!rst_n) begin
         qb.delete();
         b_last = '0;
         chk("b_rst_v_o", 96'(b_v_o), 96'(0));
         chk("b_rst_data_o", b_data_o, 96'(0));
      end else begin
         ev = (qb.size() > 0) && (qb[0].cyc == cyc);
         ed = ev ? qb[0].d : b_last;
         chk("b_ready", 96'(b_ready), 96'(edges >= c_INIT));
         chk("b_v_o", 96'(b_v_o), 96'(ev));
         chk("b_data_o", b_data_o, ed);
         if (ev) begin
            b_last = ed;
            void'(qb.pop_front());
         end
      end
   end

   task automatic idle();
      @(posedge clk); #1;
      a_v = 1'b0;
      b_v = 1'b0;
   endtask

   task automatic a_req(input logic w, input logic [8:0] ad, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] old, bm;
      exp_t        e;
      @(posedge clk); #1;
      a_v = 1'b1; a_w = w; a_addr = ad; a_data = d; a_mask = m;
      b_v = 1'b0;
      if (edges >= c_INIT) begin
         old = ma.exists(int'(ad)) ? ma[int'(ad)] : 64'h0;
         if (w) begin
            for (int k = 0; k < 8; k++) bm[k*8 +: 8] = {8{m[k]}};
            ma[int'(ad)] = (d & bm) | (old & ~bm);
         end else begin
            e.d = 96'(old);
            e.cyc = cyc + c_LAT;
            qa.push_back(e);
         end
      end
   endtask

   task automatic b_req(input logic w, input logic [5:0] ad, input logic [95:0] d, input logic [95:0] m);
      logic [95:0] old;
      exp_t        e;
      @(posedge clk); #1;
      b_v = 1'b1; b_w = w; b_addr = ad; b_data = d; b_mask = m;
      a_v = 1'b0;
      if (edges >= c_INIT) begin
         old = mb.exists(int'(ad)) ? mb[int'(ad)] : 96'h0;
         if (w) begin
            mb[int'(ad)] = (d & m) | (old & ~m);
         end else begin
            e.d = old;
            e.cyc = cyc + c_LAT;
            qb.push_back(e);
         end
      end
   endtask

   task automatic wait_init();
      for (int i = 0; i < 200 && edges < c_INIT; i++) idle();
   endtask

   initial begin
      rst_n = 1'b1;
      a_v = 1'b0; a_w = 1'b0; a_addr = '0; a_data = '0; a_mask = '0;
      b_v = 1'b0; b_w = 1'b0; b_addr = '0; b_data = '0; b_mask = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Requests during init must be ignored.
      a_req(1'b0, 9'h000, 64'h0, 8'h00);
      a_req(1'b1, 9'h0C3, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
      a_req(1'b0, 9'h0C3, 64'h0, 8'h00);
      b_req(1'b0, 6'h03, 96'h0, 96'h0);
      wait_init();

      // Initial contents are zero.
      a_req(1'b0, 9'h000, 64'h0, 8'h00);
      a_req(1'b0, 9'h1FF, 64'h0, 8'h00);
      a_req(1'b0, 9'h0C3, 64'h0, 8'h00);
      idle();

      // Byte mask.
      a_req(1'b1, 9'h040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      a_req(1'b1, 9'h040, 64'h1122_3344_5566_7788, 8'h0F);
      a_req(1'b0, 9'h040, 64'h0, 8'h00);
      idle();

      // Banking, back-to-back reads and hold.
      a_req(1'b1, 9'h005, 64'hA5, 8'hFF);
      a_req(1'b1, 9'h045, 64'h3C, 8'hFF);
      a_req(1'b0, 9'h005, 64'h0, 8'h00);
      a_req(1'b0, 9'h045, 64'h0, 8'h00);
      repeat (10) idle();
      a_req(1'b1, 9'h085, 64'h77, 8'hFF);
      repeat (3) idle();

      // Write followed immediately by a read of the same word.
      a_req(1'b1, 9'h100, 64'h0123_4567_89AB_CDEF, 8'hFF);
      a_req(1'b0, 9'h100, 64'h0, 8'h00);
      a_req(1'b0, 9'h085, 64'h0, 8'h00);
      idle();

      // Bit mask on the 96-bit instance.
      b_req(1'b1, 6'h03, {96{1'b1}}, {96{1'b1}});
      b_req(1'b1, 6'h03, 96'h0, 96'h20);
      b_req(1'b0, 6'h03, 96'h0, 96'h0);
      b_req(1'b0, 6'h04, 96'h0, 96'h0);
      repeat (3) idle();

      // Reset in the cycle after a read request.
      a_req(1'b0, 9'h005, 64'h0, 8'h00);
      b_req(1'b0, 6'h03, 96'h0, 96'h0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      a_v = 1'b0;
      b_v = 1'b0;
      ma.delete();
      mb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      a_req(1'b0, 9'h005, 64'h0, 8'h00);
      wait_init();
      a_req(1'b0, 9'h005, 64'h0, 8'h00);
      a_req(1'b0, 9'h040, 64'h0, 8'h00);
      b_req(1'b0, 6'h03, 96'h0, 96'h0);
      repeat (4) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hard_mem_1rw_mask_banked_wrapper.md
Name: hard_mem_1rw_mask_banked_wrapper

Overview:
Parametrised single-port (1RW) masked memory wrapper that tiles fakeram45 macros along depth into NUM_BANKS banks. It generalises bit-mask and byte-mask operation through a mask-granularity parameter. The wrapper adds:
- a read-valid output with a held read-data register;
- a power-on zero-initialisation sequencer.

It sits between cache/TLB/tag datapaths and the hard macros.

Parameters:
WIDTH, 64, data width in bits
DEPTH, 512, total words; power of 2; multiple of BANK_DEPTH
BANK_DEPTH, 64, words per macro; macro chosen by generate from supported (BANK_DEPTH x WIDTH) fakeram45 sizes; unsupported pair is an elaboration error
MASK_GRAN, 8, data bits per mask bit (1 = bit mask, 8 = byte mask); WIDTH % MASK_GRAN == 0
MASK_W, WIDTH/MASK_GRAN, derived, not overridable
ADDR_W, $clog2(DEPTH), derived

Ports:
clk_i  input  1  clock; all logic rising-edge
reset_n_i  input  1  asynchronous active-low reset
v_i  input  1  request valid; sampled only when ready_o=1
w_i  input  1  1 = write, 0 = read
addr_i  input  ADDR_W  word address; upper log2(NUM_BANKS) bits select bank
data_i  input  WIDTH  write data
w_mask_i  input  MASK_W  per-granule write enable; bit k covers data bits [k*MASK_GRAN +: MASK_GRAN]
ready_o  output  1  1 = init complete, requests accepted
v_o  output  1  read data valid pulse
data_o  output  WIDTH  read data; held between reads

Behaviour:
- Reset (async assert, sync release):
  - state = INIT, init counter = 0.
  - ready_o = 0, v_o = 0, data_o = 0, hold register = 0, registered bank index = 0.
- FSM states: INIT, READY.
  - INIT: each cycle, drive all banks with ce=1, we=1, full mask, wd=0, bank-local address = init counter. Counter increments each cycle.
  - When counter = BANK_DEPTH-1, the next state is READY. INIT lasts exactly BANK_DEPTH cycles after reset release.
  - READY is terminal until reset.
- ready_o = (state == READY), registered.
- Any v_i while ready_o = 0 is ignored: no macro access, no v_o.
- Accepted write (v_i & w_i & ready_o):
  - Only the selected bank gets ce=1, we=1.
  - Macro bit mask is each w_mask_i bit replicated MASK_GRAN times.
  - Unmasked bits retain their old value.
  - No v_o.
- Accepted read (v_i & ~w_i & ready_o) in cycle N:
  - Selected bank gets ce=1, we=0.
  - Bank index is registered.
  - In cycle N+1: v_o = 1 and data_o = rd_out of the registered bank.
- Non-selected banks: ce=0.
- Hold behaviour:
  - When v_o = 1, the hold register captures data_o.
  - data_o = v_o ? bank rd_out : hold register.
  - data_o is stable until the next read completes; writes and idle cycles do not disturb it.
- Back-to-back reads are supported: one per cycle, v_o high continuously.
- Write at cycle N followed by a read of the same address at N+1 returns the new data at N+2.
- Reset asserted mid-operation:
  - Any in-flight read is dropped (v_o = 0 immediately, data_o = 0).
  - Initialisation restarts from address 0 after release.
- An address beyond DEPTH is impossible by construction (DEPTH is a power of 2).

Optional Feature:
Macro HARD_MEM_OUT_REG_EN.
- Defined:
  - An extra output pipeline register is placed after the bank read mux.
  - Read latency is 2: request at N gives v_o and data at N+2.
  - Fully pipelined; back-to-back reads still give one result per cycle.
  - The output register resets to 0; hold semantics apply at the registered output.
- Undefined: latency 1 as described under Behaviour.

Test Plan:
- Init sequencing: release reset with BANK_DEPTH=64 -> ready_o=0 for exactly 64 cycles, then 1. v_i=1 pulsed during init -> v_o never asserted.
- Init zeroing: WIDTH=64, DEPTH=512; after ready_o, read addr 0x000, 0x1FF, 0x0C3 -> data_o=0, v_o pulses 1 cycle after each request.
- Byte mask (MASK_GRAN=8):
  - write 0xFFFF_FFFF_FFFF_FFFF to 0x040, full mask;
  - then write 0x1122_3344_5566_7788 with mask 0x0F;
  - then read -> data_o=0xFFFF_FFFF_5566_7788.
- Bit mask (WIDTH=96, MASK_GRAN=1): write all-ones then all-zeros with mask bit 5 only -> read returns all-ones except bit 5 = 0.
- Banking and hold:
  - write 0xA5 to addr 0x005 and 0x3C to addr 0x045 (different banks);
  - back-to-back reads -> v_o high 2 cycles, data 0xA5 then 0x3C;
  - 10 idle cycles plus one write -> data_o stays 0x3C.
- Reset mid-read: assert reset_n_i=0 in the cycle after a read request -> v_o=0, data_o=0, ready_o=0; after release, init repeats (64 cycles), previously written data reads back as 0.
